// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite single-port SRAM target with programmable wait states,
// little-endian byte-lane writes and a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HSEL           slave select from the address decoder
//   HADDR          address-phase byte address
//   HTRANS         transfer type (NONSEQ/SEQ start a transfer)
//   HWRITE         1 = write
//   HSIZE          0 = byte, 1 = halfword, 2 = word
//   HWDATA         write data, valid for the whole data phase
//   HREADY         bus-level ready from the slave mux
//   HREADYOUT      this slave's ready
//   HRESP          0 = OKAY, 1 = ERROR
//   HRDATA         read data (full word, zero outside an OKAY read data phase)
module ahb_sram_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so the range limit itself is representable.
  localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH + 1)'(MEM_DEPTH) << 2;
  localparam logic [2:0] WaitInit = 3'(WAIT_STATES - 1);
  localparam bit NoWait = (WAIT_STATES == 0);

  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [2:0]            r_wait_cnt;
  logic [2:0]            w_wait_cnt_next;
  logic [IdxW-1:0]       r_idx;
  logic                  r_write;
  logic [1:0]            r_size;
  logic [1:0]            r_lo;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [IdxW-1:0]       w_idx;
  logic [1:0]            w_lo;
  logic                  w_oor;
  logic                  w_err;
  logic                  w_active;
  logic                  w_can_accept;
  logic                  w_take;
  logic                  w_commit;
  logic                  w_fwd;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Address decode. Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign w_offset = HADDR - BASE_ADDR;
  assign w_idx    = w_offset[IdxW+1:2];
  assign w_lo     = w_offset[1:0];
  assign w_oor    = ({1'b0, w_offset} >= MemBytes);

  assign w_err = w_oor
               | (HSIZE > 3'd2)
               | ((HSIZE == 3'd1) & w_lo[0])
               | ((HSIZE == 3'd2) & (w_lo != 2'b00));

  assign w_active     = (HTRANS == TransNonseq) | (HTRANS == TransSeq);
  // Only states that drive HREADYOUT high can start a new data phase.
  assign w_can_accept = (r_state == StIdle) | (r_state == StData) | (r_state == StErr2);
  assign w_take       = HSEL & w_active & HREADY & w_can_accept;

  // The edge ending an OKAY write data phase is the commit edge.
  assign w_commit = (r_state == StData) & r_write;
  assign w_fwd    = w_commit & (r_idx == w_idx);

  // Little-endian byte enables of the transfer currently in its data phase.
  always_comb begin
    w_be = 4'b0000;
    unique case (r_size)
      2'd0:    w_be[r_lo] = 1'b1;
      2'd1:    w_be = r_lo[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Read word for a newly accepted read, merged with a write committing to the same word.
  always_comb begin
    w_rd_word = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_fwd && w_be[b]) begin
        w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      StIdle, StData, StErr2: begin
        if (w_take) begin
          if (w_err) begin
            w_state_next = StErr1;
          end else if (NoWait) begin
            w_state_next = StData;
          end else begin
            w_state_next    = StWait;
            w_wait_cnt_next = WaitInit;
          end
        end else begin
          w_state_next = StIdle;
        end
      end
      StWait: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_next = StData;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 3'd1;
        end
      end
      StErr1:  w_state_next = StErr2;
      default: w_state_next = StIdle;
    endcase
  end

  // Control and data-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= StIdle;
      r_wait_cnt <= 3'd0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_lo       <= 2'd0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_take) begin
        r_idx   <= w_idx;
        r_write <= HWRITE;
        r_size  <= HSIZE[1:0];
        r_lo    <= w_lo;
        if (!HWRITE && !w_err) begin
          r_rdata <= w_rd_word;
        end
      end
    end
  end

  // Storage array: not reset. Reset forces r_state out of StData, which blocks any commit.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Response outputs decoded from the data-phase state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    unique case (r_state)
      StWait: begin
        HREADYOUT = 1'b0;
        if (!r_write) HRDATA = r_rdata;
      end
      StData: begin
        if (!r_write) HRDATA = r_rdata;
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with zero wait states, one with three.
module tb_ahb_sram_slave;

  localparam logic [31:0] Base = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_block;
  logic        hready0, hready3;
  logic        ready0, resp0, ready3, resp3;
  logic [31:0] rdata0, rdata3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Single-slave bus: the mux returns each slave's own ready, optionally stalled.
  assign hready0 = ready0;
  assign hready3 = ready3 & ~hready_block;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
    .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready3),
    .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic s0, input logic s3, input logic [31:0] a,
                            input logic w, input logic [2:0] sz);
    sel0 = s0; sel3 = s3; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
  endtask

  task automatic bus_idle();
    sel0 = 1'b0; sel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic write0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_phase(1'b1, 1'b0, a, 1'b1, sz);
    tick();
    hwdata = d;
    bus_idle();
    tick();
  endtask

  task automatic read0(input logic [31:0] a, output logic [31:0] rd, output logic rdy);
    addr_phase(1'b1, 1'b0, a, 1'b0, 3'd2);
    tick();
    rd = rdata0; rdy = ready0;
    bus_idle();
    tick();
  endtask

  // Accept edge, three wait cycles, then the data cycle ends at the commit edge.
  task automatic write3(input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b0, 1'b1, a, 1'b1, 3'd2);
    tick();
    hwdata = d;
    bus_idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hready_block = 1'b0; hwdata = '0; haddr = '0; hsize = 3'd0;
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ready0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0})
        $display("FAIL reset_dut0[%0d]: got %b/%b/%h want 1/0/00000000", i, ready0, resp0, rdata0);
      else n_pass++;
      n_checks++;
      if ({ready3, resp3, rdata3} !== {1'b1, 1'b0, 32'h0})
        $display("FAIL reset_dut3[%0d]: got %b/%b/%h want 1/0/00000000", i, ready3, resp3, rdata3);
      else n_pass++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    addr_phase(1'b1, 1'b0, Base + 32'h10, 1'b1, 3'd2);
    tick();
    n_checks++;
    if (ready0 !== 1'b1) $display("FAIL wr_data_ready: got %b want 1", ready0);
    else n_pass++;
    hwdata = 32'hDEAD_BEEF;
    bus_idle();
    tick();
    addr_phase(1'b1, 1'b0, Base + 32'h10, 1'b0, 3'd2);
    tick();
    n_checks++;
    if ({ready0, resp0, rdata0} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
      $display("FAIL rd_deadbeef: got %b/%b/%h want 1/0/deadbeef", ready0, resp0, rdata0);
    else n_pass++;
    bus_idle();
    tick();
    n_checks++;
    if ({ready0, rdata0} !== {1'b1, 32'h0})
      $display("FAIL idle_after_read: got %b/%h want 1/00000000", ready0, rdata0);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic        rdy;
    write0(Base + 32'h20, 3'd2, 32'h1122_3344);
    write0(Base + 32'h21, 3'd0, 32'h0000_AA00);
    read0(Base + 32'h20, rd, rdy);
    n_checks++;
    if ({rdy, rd} !== {1'b1, 32'h1122_AA44})
      $display("FAIL byte_write: got %b/%h want 1/1122aa44", rdy, rd);
    else n_pass++;
    write0(Base + 32'h22, 3'd1, 32'hBEEF_0000);
    read0(Base + 32'h20, rd, rdy);
    n_checks++;
    if ({rdy, rd} !== {1'b1, 32'hBEEF_AA44})
      $display("FAIL half_write: got %b/%h want 1/beefaa44", rdy, rd);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    write0(Base + 32'h30, 3'd2, 32'h1234_5678);
    addr_phase(1'b1, 1'b0, Base + 32'h30, 1'b1, 3'd2);
    tick();
    hwdata = 32'hCAFE_F00D;
    addr_phase(1'b1, 1'b0, Base + 32'h30, 1'b0, 3'd2);
    tick();
    n_checks++;
    if ({ready0, rdata0} !== {1'b1, 32'hCAFE_F00D})
      $display("FAIL fwd_word: got %b/%h want 1/cafef00d", ready0, rdata0);
    else n_pass++;
    addr_phase(1'b1, 1'b0, Base + 32'h31, 1'b1, 3'd0);
    tick();
    hwdata = 32'h0000_5500;
    addr_phase(1'b1, 1'b0, Base + 32'h30, 1'b0, 3'd2);
    tick();
    n_checks++;
    if ({ready0, rdata0} !== {1'b1, 32'hCAFE_550D})
      $display("FAIL fwd_byte: got %b/%h want 1/cafe550d", ready0, rdata0);
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_error();
    logic [31:0] rd;
    logic        rdy;
    write0(Base, 3'd2, 32'hA5A5_5A5A);
    // Past the end of memory; the word index would alias word 0 if committed.
    addr_phase(1'b1, 1'b0, Base + 32'd4096, 1'b1, 3'd2);
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b01) $display("FAIL oor_err1: got %b%b want 01", ready0, resp0);
    else n_pass++;
    hwdata = 32'hFFFF_FFFF;
    bus_idle();
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b11) $display("FAIL oor_err2: got %b%b want 11", ready0, resp0);
    else n_pass++;
    // Misaligned word write accepted during ERR2.
    addr_phase(1'b1, 1'b0, Base + 32'h2, 1'b1, 3'd2);
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b01) $display("FAIL misal_err1: got %b%b want 01", ready0, resp0);
    else n_pass++;
    hwdata = 32'hFFFF_FFFF;
    bus_idle();
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b11) $display("FAIL misal_err2: got %b%b want 11", ready0, resp0);
    else n_pass++;
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b10) $display("FAIL err_to_idle: got %b%b want 10", ready0, resp0);
    else n_pass++;
    // Below the base address.
    addr_phase(1'b1, 1'b0, Base - 32'd4, 1'b0, 3'd2);
    tick();
    n_checks++;
    if ({ready0, resp0, rdata0} !== {2'b01, 32'h0})
      $display("FAIL below_base: got %b%b/%h want 01/00000000", ready0, resp0, rdata0);
    else n_pass++;
    bus_idle();
    repeat (2) tick();
    // Odd halfword.
    addr_phase(1'b1, 1'b0, Base + 32'h1, 1'b0, 3'd1);
    tick();
    n_checks++;
    if ({ready0, resp0} !== 2'b01) $display("FAIL odd_half: got %b%b want 01", ready0, resp0);
    else n_pass++;
    bus_idle();
    repeat (2) tick();
    read0(Base, rd, rdy);
    n_checks++;
    if ({rdy, rd} !== {1'b1, 32'hA5A5_5A5A})
      $display("FAIL err_no_write: got %b/%h want 1/a5a55a5a", rdy, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    write3(Base, 32'h0101_0101);
    write3(Base + 32'h4, 32'h0202_0202);
    addr_phase(1'b0, 1'b1, Base, 1'b0, 3'd2);
    tick();
    // Next address phase is held by the master while HREADY is low.
    addr_phase(1'b0, 1'b1, Base + 32'h4, 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ready3, resp3} !== 2'b00) $display("FAIL wait_a[%0d]: got %b%b want 00", i, ready3, resp3);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({ready3, resp3, rdata3} !== {2'b10, 32'h0101_0101})
      $display("FAIL data_a: got %b%b/%h want 10/01010101", ready3, resp3, rdata3);
    else n_pass++;
    tick();
    // A transfer addressed elsewhere (HSEL=0) must not be picked up.
    addr_phase(1'b0, 1'b0, Base + 32'h8, 1'b0, 3'd2);
    n_checks++;
    if (rdata3 !== 32'h0202_0202) $display("FAIL wait_b_rdata: got %h want 02020202", rdata3);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ready3, resp3} !== 2'b00) $display("FAIL wait_b[%0d]: got %b%b want 00", i, ready3, resp3);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({ready3, resp3, rdata3} !== {2'b10, 32'h0202_0202})
      $display("FAIL data_b: got %b%b/%h want 10/02020202", ready3, resp3, rdata3);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ready3, resp3, rdata3} !== {2'b10, 32'h0})
        $display("FAIL unselected[%0d]: got %b%b/%h want 10/00000000", i, ready3, resp3, rdata3);
      else n_pass++;
    end
    // Bus stalled by another slave: no accept while HREADY is low.
    hready_block = 1'b1;
    addr_phase(1'b0, 1'b1, Base, 1'b0, 3'd2);
    tick();
    n_checks++;
    if ({ready3, rdata3} !== {1'b1, 32'h0})
      $display("FAIL stall_no_accept: got %b/%h want 1/00000000", ready3, rdata3);
    else n_pass++;
    hready_block = 1'b0;
    tick();
    n_checks++;
    if (ready3 !== 1'b0) $display("FAIL stall_release: got %b want 0", ready3);
    else n_pass++;
    bus_idle();
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_forwarding();
    test_error();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
